// File: rtl/hazard_controller_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM encoding, register
// constants and the bundle of control outputs driven toward the ID stage.
package hazard_controller_pkg;

   localparam int unsigned REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FREEZE = 2'd1,
      ERROR  = 2'd2
   } hc_state_e;

   typedef struct packed {
      logic data_hazard;
      logic control_hazard;
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic pipe_freeze;
      logic error;
   } hc_ctrl_t;

   localparam hc_ctrl_t CTRL_PROCEED = '{data_hazard: 1'b1, control_hazard: 1'b0,
                                         pc_write: 1'b1, if_id_write: 1'b1,
                                         if_id_flush: 1'b0, pipe_freeze: 1'b0,
                                         error: 1'b0};

   localparam hc_ctrl_t CTRL_RESET   = '{data_hazard: 1'b1, control_hazard: 1'b0,
                                         pc_write: 1'b0, if_id_write: 1'b0,
                                         if_id_flush: 1'b1, pipe_freeze: 1'b1,
                                         error: 1'b0};

   localparam hc_ctrl_t CTRL_STALL   = '{data_hazard: 1'b0, control_hazard: 1'b0,
                                         pc_write: 1'b0, if_id_write: 1'b0,
                                         if_id_flush: 1'b0, pipe_freeze: 1'b0,
                                         error: 1'b0};

   localparam hc_ctrl_t CTRL_FLUSH   = '{data_hazard: 1'b1, control_hazard: 1'b1,
                                         pc_write: 1'b1, if_id_write: 1'b1,
                                         if_id_flush: 1'b1, pipe_freeze: 1'b0,
                                         error: 1'b0};

   localparam hc_ctrl_t CTRL_FREEZE  = '{data_hazard: 1'b1, control_hazard: 1'b0,
                                         pc_write: 1'b0, if_id_write: 1'b0,
                                         if_id_flush: 1'b0, pipe_freeze: 1'b1,
                                         error: 1'b0};

   localparam hc_ctrl_t CTRL_ERROR   = '{data_hazard: 1'b1, control_hazard: 1'b1,
                                         pc_write: 1'b0, if_id_write: 1'b0,
                                         if_id_flush: 1'b0, pipe_freeze: 1'b1,
                                         error: 1'b1};

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use / branch-operand stalls, taken-branch
// flush, dmem freeze with deferred flush, watchdog trap and activity counters.
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned FREEZE_MAX = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_branch,
   input  logic             id_jump,
   input  logic             branch_taken,
   input  logic             id_ex_mem_read,
   input  logic             id_ex_reg_write,
   input  logic [4:0]       id_ex_dest,
   input  logic             ex_mem_mem_read,
   input  logic [4:0]       ex_mem_dest,
   input  logic             dmem_busy,
   output logic             data_hazard,
   output logic             control_hazard,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             pipe_freeze,
   output logic             error,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int unsigned FRZ_W = (FREEZE_MAX > 2) ? $clog2(FREEZE_MAX) : 1;
   localparam logic [FRZ_W-1:0] FRZ_LAST = FRZ_W'(FREEZE_MAX - 1);

   hc_state_e        state, state_nxt;
   logic [FRZ_W-1:0] frz_cnt, frz_cnt_nxt;
   logic             flush_pend, flush_pend_nxt;
   hc_ctrl_t         ctrl;
   logic             stall_inc, flush_inc;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   logic ex_hit, mem_hit, load_use, br_dep, dstall, flush_req;

   // x0 is hard-wired, so a zero destination never matches a source
   assign ex_hit    = (id_ex_dest != REG_ZERO) &&
                      ((id_ex_dest == id_rs) || (id_ex_dest == id_rt));
   assign mem_hit   = (ex_mem_dest != REG_ZERO) &&
                      ((ex_mem_dest == id_rs) || (ex_mem_dest == id_rt));
   assign load_use  = id_ex_mem_read & ex_hit;
   assign br_dep    = id_branch & ((id_ex_reg_write & ex_hit) |
                                   (ex_mem_mem_read & mem_hit));
   assign dstall    = load_use | br_dep;
   assign flush_req = branch_taken | id_jump;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= RUN;
         frz_cnt    <= '0;
         flush_pend <= 1'b0;
      end else begin
         state      <= state_nxt;
         frz_cnt    <= frz_cnt_nxt;
         flush_pend <= flush_pend_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      frz_cnt_nxt    = frz_cnt;
      flush_pend_nxt = flush_pend;
      ctrl           = CTRL_PROCEED;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;

      if (!reset) begin
         ctrl           = CTRL_RESET;
         state_nxt      = RUN;
         frz_cnt_nxt    = '0;
         flush_pend_nxt = 1'b0;
      end else begin
         case (state)
            ERROR: begin
               ctrl      = CTRL_ERROR;
               stall_inc = 1'b1;
            end
            // FREEZE behaves as RUN in the cycle dmem_busy releases, so that
            // cycle is the first RUN cycle and carries any deferred flush
            RUN, FREEZE: begin
               if (dmem_busy) begin
                  ctrl           = CTRL_FREEZE;
                  stall_inc      = 1'b1;
                  flush_pend_nxt = flush_pend | flush_req;
                  if (frz_cnt == FRZ_LAST) begin
                     state_nxt = ERROR;
                  end else begin
                     state_nxt   = FREEZE;
                     frz_cnt_nxt = frz_cnt + FRZ_W'(1);
                  end
               end else begin
                  state_nxt      = RUN;
                  frz_cnt_nxt    = '0;
                  flush_pend_nxt = 1'b0;
                  if (dstall) begin
                     ctrl      = CTRL_STALL;
                     stall_inc = 1'b1;
                  end else if (flush_req || flush_pend) begin
                     ctrl      = CTRL_FLUSH;
                     flush_inc = 1'b1;
                  end
               end
            end
            default: begin
               state_nxt = RUN;
            end
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

   assign data_hazard    = ctrl.data_hazard;
   assign control_hazard = ctrl.control_hazard;
   assign pc_write       = ctrl.pc_write;
   assign if_id_write    = ctrl.if_id_write;
   assign if_id_flush    = ctrl.if_id_flush;
   assign pipe_freeze    = ctrl.pipe_freeze;
   assign error          = ctrl.error;

   // Counters read as zero for the whole reset cycle, not just after the edge
   assign stall_cycles = reset ? stall_cnt : '0;
   assign flush_events = reset ? flush_cnt : '0;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a per-cycle behavioural model of the
// hazard rules, a negedge compare process, and hand-computed anchor checks.
module tb_hazard_controller;

   localparam int unsigned CNT_W      = 4;
   localparam int unsigned FREEZE_MAX = 64;
   localparam int          CNT_MAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       id_rs, id_rt, id_ex_dest, ex_mem_dest;
   logic             id_branch, id_jump, branch_taken;
   logic             id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read, dmem_busy;
   logic             data_hazard, control_hazard, pc_write, if_id_write;
   logic             if_id_flush, pipe_freeze, error;
   logic [CNT_W-1:0] stall_cycles, flush_events;

   int vectors     = 0;
   int miscompares = 0;

   // Model state: length of the current dmem_busy run, trap flag, deferred
   // flush and the two activity counts
   int m_busy_run = 0;
   bit m_err      = 1'b0;
   bit m_pend     = 1'b0;
   int m_stall    = 0;
   int m_flush    = 0;

   bit check_en = 1'b0;
   bit e_dh, e_ch, e_pcw, e_ifw, e_fl, e_frz, e_err;
   int e_stall, e_flushc;

   hazard_controller #(.CNT_W(CNT_W), .FREEZE_MAX(FREEZE_MAX)) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_branch       (id_branch),
      .id_jump         (id_jump),
      .branch_taken    (branch_taken),
      .id_ex_mem_read  (id_ex_mem_read),
      .id_ex_reg_write (id_ex_reg_write),
      .id_ex_dest      (id_ex_dest),
      .ex_mem_mem_read (ex_mem_mem_read),
      .ex_mem_dest     (ex_mem_dest),
      .dmem_busy       (dmem_busy),
      .data_hazard     (data_hazard),
      .control_hazard  (control_hazard),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .pipe_freeze     (pipe_freeze),
      .error           (error),
      .stall_cycles    (stall_cycles),
      .flush_events    (flush_events)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("data_hazard",    32'(data_hazard),    32'(e_dh));
         chk("control_hazard", 32'(control_hazard), 32'(e_ch));
         chk("pc_write",       32'(pc_write),       32'(e_pcw));
         chk("if_id_write",    32'(if_id_write),    32'(e_ifw));
         chk("if_id_flush",    32'(if_id_flush),    32'(e_fl));
         chk("pipe_freeze",    32'(pipe_freeze),    32'(e_frz));
         chk("error",          32'(error),          32'(e_err));
         chk("stall_cycles",   32'(stall_cycles),   32'(e_stall));
         chk("flush_events",   32'(flush_events),   32'(e_flushc));
      end
   end

   function automatic int sat_inc(input int v);
      return (v < CNT_MAX) ? v + 1 : v;
   endfunction

   function automatic bit reads(input logic [4:0] dest);
      return (dest != 5'd0) && (dest == id_rs || dest == id_rt);
   endfunction

   task automatic idle();
      reset           = 1'b1;
      id_rs           = 5'd0;
      id_rt           = 5'd0;
      id_branch       = 1'b0;
      id_jump         = 1'b0;
      branch_taken    = 1'b0;
      id_ex_mem_read  = 1'b0;
      id_ex_reg_write = 1'b0;
      id_ex_dest      = 5'd0;
      ex_mem_mem_read = 1'b0;
      ex_mem_dest     = 5'd0;
      dmem_busy       = 1'b0;
   endtask

   // Predict this cycle's outputs from the current inputs, then advance the model
   task automatic cyc();
      bit redirect, stall_now;
      redirect  = branch_taken | id_jump;
      stall_now = (id_ex_mem_read && reads(id_ex_dest)) ||
                  (id_branch && ((id_ex_reg_write && reads(id_ex_dest)) ||
                                 (ex_mem_mem_read && reads(ex_mem_dest))));
      {e_dh, e_ch, e_pcw, e_ifw, e_fl, e_frz, e_err} = 7'b1011000;
      e_stall  = reset ? m_stall : 0;
      e_flushc = reset ? m_flush : 0;
      if (!reset) begin
         {e_dh, e_ch, e_pcw, e_ifw, e_fl, e_frz, e_err} = 7'b1000110;
      end else if (m_err) begin
         {e_dh, e_ch, e_pcw, e_ifw, e_fl, e_frz, e_err} = 7'b1100011;
      end else if (dmem_busy) begin
         {e_dh, e_ch, e_pcw, e_ifw, e_fl, e_frz, e_err} = 7'b1000010;
      end else if (stall_now) begin
         {e_dh, e_ch, e_pcw, e_ifw, e_fl, e_frz, e_err} = 7'b0000000;
      end else if (redirect || m_pend) begin
         {e_dh, e_ch, e_pcw, e_ifw, e_fl, e_frz, e_err} = 7'b1111100;
      end
      check_en = 1'b1;
      @(posedge clk);
      if (!reset) begin
         m_busy_run = 0; m_err = 1'b0; m_pend = 1'b0; m_stall = 0; m_flush = 0;
      end else begin
         if (!e_dh || e_frz) m_stall = sat_inc(m_stall);
         if (e_fl)           m_flush = sat_inc(m_flush);
         if (!m_err) begin
            if (dmem_busy) begin
               m_busy_run++;
               m_pend = m_pend | redirect;
               if (m_busy_run >= FREEZE_MAX) m_err = 1'b1;
            end else begin
               m_busy_run = 0;
               m_pend     = 1'b0;
            end
         end
      end
      #1;
   endtask

   initial begin
      idle();
      reset = 1'b0;
      @(posedge clk);
      #1;
      cyc();
      cyc();
      idle();
      #1;
      chk("reset_stall_zero", 32'(stall_cycles), 32'd0);
      chk("reset_flush_zero", 32'(flush_events), 32'd0);
      chk("run_pc_write",     32'(pc_write),     32'd1);

      // lw r2 in EX, ID reads r2: one stall, then the bubble lets it proceed
      idle(); id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1; id_ex_dest = 5'd2;
      id_rs = 5'd2; id_rt = 5'd7;
      #1;
      chk("load_use_dh", 32'(data_hazard), 32'd0);
      chk("load_use_pc", 32'(pc_write),    32'd0);
      cyc();
      idle(); id_rs = 5'd2; id_rt = 5'd7;
      cyc();
      chk("load_use_stall_cnt", 32'(stall_cycles), 32'd1);

      // beq r3 after lw r3: stall with load in EX, stall with load in MEM, then flush
      idle(); id_branch = 1'b1; id_rs = 5'd3; id_ex_mem_read = 1'b1;
      id_ex_reg_write = 1'b1; id_ex_dest = 5'd3;
      cyc();
      idle(); id_branch = 1'b1; id_rs = 5'd3; ex_mem_mem_read = 1'b1; ex_mem_dest = 5'd3;
      cyc();
      idle(); id_branch = 1'b1; id_rs = 5'd3; branch_taken = 1'b1;
      #1;
      chk("br_load_flush", 32'(if_id_flush), 32'd1);
      cyc();
      idle();
      #1;
      chk("br_load_flush_one", 32'(if_id_flush), 32'd0);
      cyc();
      chk("br_load_stall_cnt", 32'(stall_cycles), 32'd3);
      chk("br_load_flush_cnt", 32'(flush_events), 32'd1);

      // Branch after ALU op writing r4: a single stall
      idle(); id_branch = 1'b1; id_rt = 5'd4; id_ex_reg_write = 1'b1; id_ex_dest = 5'd4;
      cyc();
      idle(); id_branch = 1'b1; id_rt = 5'd4;
      cyc();
      chk("br_alu_stall_cnt", 32'(stall_cycles), 32'd4);

      // Register x0 never matches
      idle(); id_ex_mem_read = 1'b1; id_ex_dest = 5'd0; id_rs = 5'd0;
      #1;
      chk("x0_no_stall", 32'(data_hazard), 32'd1);
      cyc();
      idle(); id_branch = 1'b1; id_ex_reg_write = 1'b1; ex_mem_mem_read = 1'b1;
      cyc();

      // Jump coincident with a load-use stall is not flushed until it re-evaluates
      idle(); id_jump = 1'b1; id_ex_mem_read = 1'b1; id_ex_dest = 5'd5; id_rt = 5'd5;
      #1;
      chk("jump_stall_no_flush", 32'(if_id_flush), 32'd0);
      cyc();
      idle(); id_jump = 1'b1;
      cyc();
      chk("jump_stall_cnt", 32'(stall_cycles), 32'd5);
      chk("jump_flush_cnt", 32'(flush_events), 32'd2);

      // dmem_busy for 3 cycles, branch taken in the 2nd: flush on first RUN cycle
      idle(); dmem_busy = 1'b1;
      cyc();
      branch_taken = 1'b1;
      cyc();
      branch_taken = 1'b0;
      cyc();
      idle();
      #1;
      chk("deferred_flush", 32'(if_id_flush), 32'd1);
      cyc();
      idle();
      cyc();
      chk("freeze_stall_cnt", 32'(stall_cycles), 32'd8);
      chk("freeze_flush_cnt", 32'(flush_events), 32'd3);

      // Reset mid-freeze drops the pending flush
      idle(); dmem_busy = 1'b1; id_jump = 1'b1;
      cyc();
      idle(); reset = 1'b0;
      cyc();
      idle();
      #1;
      chk("reset_drops_pend", 32'(if_id_flush), 32'd0);
      cyc();

      // Watchdog: FREEZE_MAX busy cycles trap, sticky until reset
      idle(); dmem_busy = 1'b1;
      repeat (FREEZE_MAX) cyc();
      #1;
      chk("watchdog_trip", 32'(error), 32'd1);
      idle();
      repeat (3) cyc();
      chk("error_sticky", 32'(error), 32'd1);
      idle(); reset = 1'b0;
      cyc();
      idle();
      #1;
      chk("error_cleared", 32'(error), 32'd0);
      chk("error_cleared_pc", 32'(pc_write), 32'd1);
      cyc();

      // Saturation of both counters
      idle(); id_ex_mem_read = 1'b1; id_ex_dest = 5'd9; id_rs = 5'd9;
      repeat (CNT_MAX) cyc();
      chk("stall_at_max", 32'(stall_cycles), 32'(CNT_MAX));
      cyc();
      chk("stall_saturated", 32'(stall_cycles), 32'(CNT_MAX));
      idle(); id_jump = 1'b1;
      repeat (CNT_MAX + 2) cyc();
      chk("flush_saturated", 32'(flush_events), 32'(CNT_MAX));

      // Mixed vectors over a small register set to exercise interactions
      for (int i = 0; i < 150; i++) begin
         idle();
         reset           = ($urandom_range(0, 31) != 0);
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         id_branch       = 1'($urandom_range(0, 1));
         id_jump         = ($urandom_range(0, 5) == 0);
         branch_taken    = ($urandom_range(0, 3) == 0);
         id_ex_mem_read  = 1'($urandom_range(0, 1));
         id_ex_reg_write = 1'($urandom_range(0, 1));
         id_ex_dest      = 5'($urandom_range(0, 3));
         ex_mem_mem_read = 1'($urandom_range(0, 1));
         ex_mem_dest     = 5'($urandom_range(0, 3));
         dmem_busy       = ($urandom_range(0, 5) == 0);
         cyc();
      end

      check_en = 1'b0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
